// File: rtl/rot_pkg.sv
// Shared definitions for the rotating-framebuffer scan sequencer.
//   rot_state_t : sequencer FSM states
//   coord_t     : signed 16-bit source coordinate (wraps, no saturation)
//   SIN_OFFSET  : sin(a) is read from the cosine table at a - SIN_OFFSET
//   COS_SCALE   : fixed-point scale of the cosine table entries
package rot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_COS,
    ST_FETCH_SIN,
    ST_FETCH_START,
    ST_WAIT_LINE,
    ST_RUN
  } rot_state_t;

  typedef logic signed [15:0] coord_t;

  localparam int SIN_OFFSET = 64;
  localparam int COS_SCALE  = 64;

  // Sign-extend an 8-bit table entry to coordinate width.
  function automatic coord_t sext8(input logic signed [7:0] x);
    return coord_t'(x);
  endfunction

endpackage

// File: rtl/rot_coord_stepper.sv
// Rotated source-coordinate walker.
//   load_row   : capture the frame start point into row_u/row_v
//   start_line : copy row_u/row_v into the pixel coordinates u/v
//   step_pix   : advance one pixel along the line (u+=cs, v+=sn)
//   step_row   : advance the row origin one line (row_u-=sn, row_v+=cs)
//   u, v       : current pixel coordinates
module rot_coord_stepper
  import rot_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_row,
  input  coord_t row_u0,
  input  coord_t row_v0,
  input  logic   start_line,
  input  logic   step_pix,
  input  logic   step_row,
  input  coord_t cs,
  input  coord_t sn,
  output coord_t u,
  output coord_t v
);

  coord_t row_u, row_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_u <= '0;
      row_v <= '0;
      u     <= '0;
      v     <= '0;
    end else begin
      if (load_row) begin
        row_u <= row_u0;
        row_v <= row_v0;
      end else if (step_row) begin
        row_u <= row_u - sn;
        row_v <= row_v + cs;
      end
      if (start_line) begin
        u <= row_u;
        v <= row_v;
      end else if (step_pix) begin
        u <= u + cs;
        v <= v + sn;
      end
    end
  end

endmodule

// File: rtl/rot_scan_sequencer.sv
// Per-frame / per-line scan sequencer for the rotating framebuffer.
// Fetches cos, sin (time-shared cosine port) and the start point for the
// current angle, then emits rotated source coordinates line by line on a
// valid/ready stream.
//   frame_start/line_start : control pulses
//   rot_en                 : advance angle by ANGLE_STEP after each setup
//   cos_ad/cos_rd          : cosine table port (combinational read)
//   sta_ad/sta_rd          : start table port, {u0, v0}
//   pix_valid/ready/u/v/last : pixel stream
//   angle, frame_done, line_overrun : status
module rot_scan_sequencer
  import rot_pkg::*;
#(
  parameter int         H_PIX      = 256,
  parameter int         V_LINES    = 256,
  parameter logic [7:0] ANGLE_STEP = 8'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        rot_en,
  output logic [7:0]  cos_ad,
  input  logic [7:0]  cos_rd,
  output logic [7:0]  sta_ad,
  input  logic [31:0] sta_rd,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_u,
  output logic [15:0] pix_v,
  output logic        pix_last,
  output logic [7:0]  angle,
  output logic        frame_done,
  output logic        line_overrun
);

  localparam int PW = $clog2(H_PIX);
  localparam int LW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  rot_state_t    state, state_nx;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  coord_t        cs, sn, u, v;
  logic          load_row, start_line, step_pix, step_row, cap_cs, cap_sn;
  logic          last_pix, last_line;

  assign last_pix  = (pix_cnt == PW'(H_PIX - 1));
  assign last_line = (line_cnt == LW'(V_LINES - 1));
  assign pix_u     = u;
  assign pix_v     = v;

  rot_coord_stepper u_stepper (
    .clk       (clk),
    .rst       (rst),
    .load_row  (load_row),
    .row_u0    (coord_t'(sta_rd[31:16])),
    .row_v0    (coord_t'(sta_rd[15:0])),
    .start_line(start_line),
    .step_pix  (step_pix),
    .step_row  (step_row),
    .cs        (cs),
    .sn        (sn),
    .u         (u),
    .v         (v)
  );

  // frame_start overrides every state and suppresses all datapath updates,
  // so an aborted frame leaves no trace beyond the restarted setup.
  always_comb begin
    state_nx   = state;
    cos_ad     = '0;
    sta_ad     = '0;
    load_row   = 1'b0;
    start_line = 1'b0;
    step_pix   = 1'b0;
    step_row   = 1'b0;
    cap_cs     = 1'b0;
    cap_sn     = 1'b0;
    pix_valid  = 1'b0;
    pix_last   = 1'b0;
    if (state == ST_RUN) begin
      pix_valid = 1'b1;
      pix_last  = last_pix;
    end
    if (frame_start) begin
      state_nx = ST_FETCH_COS;
    end else begin
      case (state)
        ST_FETCH_COS: begin
          cos_ad   = angle;
          cap_cs   = 1'b1;
          state_nx = ST_FETCH_SIN;
        end
        ST_FETCH_SIN: begin
          cos_ad   = angle - 8'(SIN_OFFSET);
          cap_sn   = 1'b1;
          state_nx = ST_FETCH_START;
        end
        ST_FETCH_START: begin
          sta_ad   = angle;
          load_row = 1'b1;
          state_nx = ST_WAIT_LINE;
        end
        ST_WAIT_LINE: begin
          if (line_start) begin
            start_line = 1'b1;
            state_nx   = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pix_ready) begin
            step_pix = 1'b1;
            if (last_pix) begin
              step_row = 1'b1;
              state_nx = last_line ? ST_IDLE : ST_WAIT_LINE;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      angle        <= '0;
      cs           <= '0;
      sn           <= '0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      frame_done   <= 1'b0;
      line_overrun <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= 1'b0;
      if (state == ST_RUN && line_start)
        line_overrun <= 1'b1;
      if (cap_cs)
        cs <= sext8(cos_rd);
      if (cap_sn)
        sn <= sext8(cos_rd);
      // Fetched values belong to the pre-increment angle.
      if (load_row) begin
        line_cnt <= '0;
        if (rot_en)
          angle <= angle + ANGLE_STEP;
      end
      if (start_line)
        pix_cnt <= '0;
      else if (step_pix)
        pix_cnt <= pix_cnt + PW'(1);
      if (step_row) begin
        line_cnt <= line_cnt + LW'(1);
        if (last_line)
          frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rot_scan_sequencer.sv
module tb_rot_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default geometry (256x256, step 1)
  logic        rst, frame_start, line_start, rot_en, pix_ready;
  logic [7:0]  cos_ad, cos_rd, sta_ad, angle;
  logic [31:0] sta_rd;
  logic        pix_valid, pix_last, frame_done, line_overrun;
  logic [15:0] pix_u, pix_v;

  // DUT B: small geometry (4x2, step 3)
  logic        rst_b, frame_start_b, line_start_b, rot_en_b, pix_ready_b;
  logic [7:0]  cos_ad_b, cos_rd_b, sta_ad_b, angle_b;
  logic [31:0] sta_rd_b;
  logic        pix_valid_b, pix_last_b, frame_done_b, line_overrun_b;
  logic [15:0] pix_u_b, pix_v_b;

  function automatic logic [7:0] cos_tab(input logic [7:0] a);
    case (a)
      8'd0:    return 8'd64;
      8'd64:   return 8'd0;
      8'd128:  return 8'hC0;
      8'd192:  return 8'd0;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] sta_tab(input logic [7:0] a);
    case (a)
      8'd0:    return 32'h0000_0800;
      8'd64:   return 32'h0800_4000;
      default: return {8'h00, a, 8'h10, a};
    endcase
  endfunction

  always_comb begin
    cos_rd   = cos_tab(cos_ad);
    sta_rd   = sta_tab(sta_ad);
    cos_rd_b = cos_tab(cos_ad_b);
    sta_rd_b = sta_tab(sta_ad_b);
  end

  rot_scan_sequencer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .rot_en(rot_en), .cos_ad(cos_ad), .cos_rd(cos_rd), .sta_ad(sta_ad),
    .sta_rd(sta_rd), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_u(pix_u), .pix_v(pix_v), .pix_last(pix_last), .angle(angle),
    .frame_done(frame_done), .line_overrun(line_overrun)
  );

  rot_scan_sequencer #(.H_PIX(4), .V_LINES(2), .ANGLE_STEP(8'd3)) dut_b (
    .clk(clk), .rst(rst_b), .frame_start(frame_start_b), .line_start(line_start_b),
    .rot_en(rot_en_b), .cos_ad(cos_ad_b), .cos_rd(cos_rd_b), .sta_ad(sta_ad_b),
    .sta_rd(sta_rd_b), .pix_valid(pix_valid_b), .pix_ready(pix_ready_b),
    .pix_u(pix_u_b), .pix_v(pix_v_b), .pix_last(pix_last_b), .angle(angle_b),
    .frame_done(frame_done_b), .line_overrun(line_overrun_b)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] cap_u [2][256];
  logic [15:0] cap_v [2][256];
  logic        cap_l [2][256];

  typedef struct {
    int          phase;
    int          line;
    int          idx;
    logic [15:0] u;
    logic [15:0] v;
    logic        last;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic frame_a;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    tick; tick; tick;
  endtask

  task automatic frame_b;
    frame_start_b = 1'b1;
    tick;
    frame_start_b = 1'b0;
    tick; tick; tick;
  endtask

  // Run one full line on DUT A, capturing accepted pixels into slot ln.
  task automatic line_a(input int ln, input bit rnd);
    int n;
    bit stalled;
    logic [15:0] pu, pv;
    n = 0;
    stalled = 1'b0;
    pu = '0;
    pv = '0;
    chk("valid_before_line", pix_valid, 1'b0);
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    chk("valid_latency", pix_valid, 1'b1);
    for (int c = 0; c < 4000 && n < 256; c++) begin
      if (stalled) begin
        chk("hold_valid", pix_valid, 1'b1);
        chk("hold_u", pix_u, pu);
        chk("hold_v", pix_v, pv);
      end
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_valid && pix_ready) begin
        cap_u[ln % 2][n] = pix_u;
        cap_v[ln % 2][n] = pix_v;
        cap_l[ln % 2][n] = pix_last;
        n++;
        stalled = 1'b0;
      end else begin
        stalled = pix_valid;
        pu = pix_u;
        pv = pix_v;
      end
      tick;
    end
    pix_ready = 1'b0;
    chk("line_handshakes", n, 256);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int fd_seen;

    vecs[0] = '{0, 0, 0,   16'h0000, 16'h0800, 1'b0};
    vecs[1] = '{0, 0, 1,   16'h0040, 16'h0800, 1'b0};
    vecs[2] = '{0, 0, 255, 16'h3FC0, 16'h0800, 1'b1};
    vecs[3] = '{0, 1, 0,   16'h0000, 16'h0840, 1'b0};
    vecs[4] = '{1, 0, 0,   16'h0800, 16'h4000, 1'b0};
    vecs[5] = '{1, 0, 1,   16'h0800, 16'h4040, 1'b0};
    vecs[6] = '{1, 0, 255, 16'h0800, 16'h7FC0, 1'b1};
    vecs[7] = '{1, 1, 0,   16'h07C0, 16'h4000, 1'b0};

    rst = 1'b1; frame_start = 1'b0; line_start = 1'b0; rot_en = 1'b0; pix_ready = 1'b0;
    rst_b = 1'b1; frame_start_b = 1'b0; line_start_b = 1'b0; rot_en_b = 1'b0; pix_ready_b = 1'b0;
    tick; tick;
    rst = 1'b0;
    rst_b = 1'b0;
    tick;

    chk("rst_valid", pix_valid, 1'b0);
    chk("rst_last", pix_last, 1'b0);
    chk("rst_u", pix_u, 16'h0);
    chk("rst_v", pix_v, 16'h0);
    chk("rst_angle", angle, 8'h0);
    chk("rst_cos_ad", cos_ad, 8'h0);
    chk("rst_sta_ad", sta_ad, 8'h0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_overrun", line_overrun, 1'b0);

    // Angle 0
    frame_a;
    chk("a0_angle", angle, 8'd0);
    line_a(0, 1'b0);
    line_a(1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].phase == 0) begin
        chk($sformatf("a0_u_l%0d_p%0d", vecs[i].line, vecs[i].idx), cap_u[vecs[i].line][vecs[i].idx], vecs[i].u);
        chk($sformatf("a0_v_l%0d_p%0d", vecs[i].line, vecs[i].idx), cap_v[vecs[i].line][vecs[i].idx], vecs[i].v);
        chk($sformatf("a0_last_l%0d_p%0d", vecs[i].line, vecs[i].idx), cap_l[vecs[i].line][vecs[i].idx], vecs[i].last);
      end
    end

    // Backpressure on line 2 of the angle-0 frame
    line_a(2, 1'b1);
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (cap_u[0][k] !== 16'(k * 64)) bad++;
      if (cap_v[0][k] !== 16'h0880) bad++;
      if (cap_l[0][k] !== (k == 255)) bad++;
    end
    chk("bp_sequence_errors", bad, 0);

    // Abort mid-line
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    pix_ready = 1'b1;
    tick; tick; tick;
    pix_ready = 1'b0;
    chk("abort_pre_valid", pix_valid, 1'b1);
    chk("abort_pre_u", pix_u, 16'h00C0);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    chk("abort_valid", pix_valid, 1'b0);
    fd_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (frame_done) fd_seen++;
    end
    chk("abort_no_done", fd_seen, 0);

    // Overrun
    chk("ovr_initial", line_overrun, 1'b0);
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    tick;
    chk("ovr_wait_line_start", line_overrun, 1'b0);
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    chk("ovr_set", line_overrun, 1'b1);
    frame_a;
    chk("ovr_sticky", line_overrun, 1'b1);

    // Reset mid-RUN
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    chk("rstrun_pre_valid", pix_valid, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstrun_valid", pix_valid, 1'b0);
    chk("rstrun_u", pix_u, 16'h0);
    chk("rstrun_v", pix_v, 16'h0);
    chk("rstrun_angle", angle, 8'h0);
    chk("rstrun_overrun", line_overrun, 1'b0);

    // Angle 64
    rot_en = 1'b1;
    for (int f = 0; f < 64; f++) frame_a;
    chk("a64_preload_angle", angle, 8'd64);
    rot_en = 1'b0;
    frame_a;
    chk("a64_angle", angle, 8'd64);
    line_a(0, 1'b0);
    line_a(1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].phase == 1) begin
        chk($sformatf("a64_u_l%0d_p%0d", vecs[i].line, vecs[i].idx), cap_u[vecs[i].line][vecs[i].idx], vecs[i].u);
        chk($sformatf("a64_v_l%0d_p%0d", vecs[i].line, vecs[i].idx), cap_v[vecs[i].line][vecs[i].idx], vecs[i].v);
        chk($sformatf("a64_last_l%0d_p%0d", vecs[i].line, vecs[i].idx), cap_l[vecs[i].line][vecs[i].idx], vecs[i].last);
      end
    end

    // Frame end on the small instance
    rot_en_b = 1'b1;
    frame_b;
    chk("b_angle_1", angle_b, 8'd3);
    for (int ln = 0; ln < 2; ln++) begin
      line_start_b = 1'b1;
      tick;
      line_start_b = 1'b0;
      for (int k = 0; k < 4; k++) begin
        pix_ready_b = 1'b1;
        chk($sformatf("b_valid_l%0d_p%0d", ln, k), pix_valid_b, 1'b1);
        chk($sformatf("b_u_l%0d_p%0d", ln, k), pix_u_b, 16'(k * 64));
        chk($sformatf("b_v_l%0d_p%0d", ln, k), pix_v_b, 16'(16'h0800 + ln * 64));
        chk($sformatf("b_last_l%0d_p%0d", ln, k), pix_last_b, 1'(k == 3));
        chk($sformatf("b_done_early_l%0d_p%0d", ln, k), frame_done_b, 1'b0);
        tick;
      end
      pix_ready_b = 1'b0;
      chk($sformatf("b_done_after_l%0d", ln), frame_done_b, 1'(ln == 1));
      chk($sformatf("b_valid_after_l%0d", ln), pix_valid_b, 1'b0);
    end
    tick;
    chk("b_done_one_cycle", frame_done_b, 1'b0);
    line_start_b = 1'b1;
    tick;
    line_start_b = 1'b0;
    fd_seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (pix_valid_b) fd_seen++;
      tick;
    end
    chk("b_idle_ignores_line", fd_seen, 0);
    frame_b;
    chk("b_angle_2", angle_b, 8'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rot_scan_sequencer.md
Name: rot_scan_sequencer

Overview:
Per-frame/per-line sequencer for the rotating framebuffer. It fetches the angle's cosine, sine and start coordinate from the shared cosine and start-coordinate lookup tables, then walks rotated source coordinates (u,v) across each output line. Pixels leave on a valid/ready stream to the SDRAM read / line-buffer fill logic. A single cosine-table port is time-shared between the cos and sin lookups.

Parameters:
H_PIX, 256, output pixels per line (>=2)
V_LINES, 256, output lines per frame (>=1)
ANGLE_STEP, 1, angle increment per frame when rot_en=1 (8-bit, mod 256)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
frame_start  input  1  one-cycle pulse, begin new frame
line_start  input  1  one-cycle pulse, begin next output line
rot_en  input  1  advance angle after each frame setup
cos_ad  output  8  cosine table address
cos_rd  input  8  signed cosine (scale 64), combinational in same cycle
sta_ad  output  8  start table address
sta_rd  input  32  {u0[31:16], v0[15:0]}, combinational in same cycle
pix_valid  output  1  pix_u/pix_v valid
pix_ready  input  1  consumer accepts
pix_u  output  16  signed source u coordinate
pix_v  output  16  signed source v coordinate
pix_last  output  1  last pixel of line (with pix_valid)
angle  output  8  angle of the current frame
frame_done  output  1  one-cycle pulse after last pixel of last line
line_overrun  output  1  sticky: line_start arrived while RUN

Behaviour:
- Reset: state IDLE; angle=0; all coordinates, cnts=0; pix_valid, pix_last, frame_done, line_overrun=0; cos_ad=sta_ad=0.
- States: IDLE, FETCH_COS, FETCH_SIN, FETCH_START, WAIT_LINE, RUN.
- frame_start has priority in every state: aborts any frame, drops pix_valid next cycle, -> FETCH_COS. No frame_done for an aborted frame.
- FETCH_COS: cos_ad=angle; cs<=sext(cos_rd).
- FETCH_SIN: cos_ad=angle-64 (mod 256); sn<=sext(cos_rd).
- FETCH_START: sta_ad=angle; row_u<=sta_rd[31:16], row_v<=sta_rd[15:0]; line_cnt<=0; if rot_en then angle<=angle+ANGLE_STEP. -> WAIT_LINE.
- Setup latency: frame_start to WAIT_LINE = 3 cycles. The angle output changes in the FETCH_START cycle; the fetched values belong to the pre-increment angle.
- WAIT_LINE: on line_start, u<=row_u, v<=row_v, pix_cnt<=0 -> RUN. pix_valid asserts the next cycle. line_start in other states is ignored. In RUN it also sets line_overrun, which clears only on rst.
- RUN: pix_valid=1, pix_u=u, pix_v=v, pix_last=(pix_cnt==H_PIX-1).
  - Outputs hold stable while pix_ready=0.
  - On valid&&ready: u<=u+cs, v<=v+sn, pix_cnt++.
  - On the last pixel: row_u<=row_u-sn, row_v<=row_v+cs, line_cnt++. If line_cnt==V_LINES-1, pulse frame_done and -> IDLE; else -> WAIT_LINE.
- Arithmetic: 16-bit two's complement with wrap (no saturation); cs and sn are 8-bit sign-extended.
- IDLE: outputs quiet; waits for frame_start.

Decomposition:
- Shared package rot_pkg:
  - state enum rot_state_t
  - typedef coord_t (signed 16)
  - constants SIN_OFFSET=64, COS_SCALE=64
- One sub-module rot_coord_stepper:
  - holds row_u/row_v and u/v
  - controls: load_row, start_line, step_pix, step_row
  - instantiated once by the FSM

Test Plan:
- Angle 0: rst, frame_start, line_start, pix_ready=1. Table gives cos=64, sin=0, start (0x0000,0x0800). Pixels: (0x0000,0x0800), (0x0040,0x0800), ...; pixel 255 u=0x3FC0 with pix_last. Second line starts at (0x0000,0x0840). angle=0 throughout (rot_en=0).
- Angle 64: preload angle via 64 frames with rot_en=1, ANGLE_STEP=1. Table gives cs=0, sn=64, start (0x0800,0x4000). Pixels: u fixed at 0x0800, v steps 0x4000, 0x4040, ... Row step gives u=0x07C0 for line 1.
- Backpressure: toggle pix_ready randomly -> coordinates hold while stalled; exactly H_PIX accepted per line; no duplicates or skips.
- Abort/overrun:
  - frame_start mid-line -> pix_valid=0 next cycle; FETCH_COS follows; no frame_done.
  - line_start during RUN -> line_overrun=1, stays 1 until rst.
- Frame end: V_LINES=2, H_PIX=4 -> frame_done pulses one cycle after the 8th handshake; state IDLE; line_start then ignored. With rot_en=1, ANGLE_STEP=3, angle goes 0->3->6 over two frames.
- Reset mid-RUN: rst during pix_valid=1 -> next cycle all outputs at reset values, angle=0.
